mem_stage: RTL and testbench

//  Memory-access pipeline stage, directly downstream of the execute stage.

---
 rtl/mem_stage_pkg.sv | 53 +++++
 rtl/mem_stage_if.sv | 23 ++
 rtl/mem_stage_load_ext.sv | 35 +++
 rtl/mem_stage.sv | 150 +++++++++++++++
 tb/tb_mem_stage.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the memory-access stage.
// Holds bus widths, except_zip field offsets and ld_op bit indices.
package mem_stage_pkg;

  localparam int DATA_W  = 32;
  localparam int EXC_W   = 82;
  localparam int ES2MS_W = 158;
  localparam int MS2WS_W = 152;

  // except_zip layout: flag at the top, ecode above badv
  localparam int EXC_FLAG_BIT = 81;
  localparam int ECODE_LSB    = 32;
  localparam int BADV_LSB     = 0;

  localparam logic [5:0] ECODE_ALE = 6'h09;

  // ld_op one-hot: {ld_b, ld_bu, ld_h, ld_hu, ld_w}
  localparam int LD_B  = 4;
  localparam int LD_BU = 3;
  localparam int LD_H  = 2;
  localparam int LD_HU = 1;
  localparam int LD_W  = 0;

  typedef struct packed {
    logic [4:0]       ld_op;
    logic             res_from_mem;
    logic             rf_we;
    logic [4:0]       rf_waddr;
    logic [31:0]      alu_result;
    logic [31:0]      pc;
    logic [EXC_W-1:0] except_zip;
  } es2ms_t;

  typedef struct packed {
    logic             rf_we;
    logic [4:0]       rf_waddr;
    logic [31:0]      final_result;
    logic [31:0]      pc;
    logic [EXC_W-1:0] except_zip;
  } ms2ws_t;

  // Halfword loads need addr[0]==0, word loads need addr[1:0]==0
  function automatic logic misaligned(
    input logic [4:0] ld_op,
    input logic [1:0] off
  );
    logic half;
    half = ld_op[LD_H] | ld_op[LD_HU];
    return (half & off[0]) |
           (ld_op[LD_W] & (off != 2'b00));
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Valid/allowin pipeline handshake with a payload bus.
// master drives valid/bus, slave drives allowin.
interface mem_stage_if #(
  parameter int W = 1
);

  logic         valid;
  logic         allowin;
  logic [W-1:0] bus;

  modport master (
    output valid,
    output bus,
    input  allowin
  );

  modport slave (
    input  valid,
    input  bus,
    output allowin
  );

endinterface

// File: rtl/mem_stage_load_ext.sv
// Load data extraction: picks byte/half by offset and extends.
// Purely combinational.
module load_ext
  import mem_stage_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [4:0]  ld_op,
  input  logic [1:0]  off,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Select the addressed byte/half, then extend per ld_op
  always_comb begin
    byte_sel = rdata[7:0];
    unique case (off)
      2'd0: byte_sel = rdata[7:0];
      2'd1: byte_sel = rdata[15:8];
      2'd2: byte_sel = rdata[23:16];
      2'd3: byte_sel = rdata[31:24];
    endcase
    half_sel = off[1] ? rdata[31:16] : rdata[15:0];
    result = rdata;
    unique case (1'b1)
      ld_op[LD_B]:  result = {{24{byte_sel[7]}}, byte_sel};
      ld_op[LD_BU]: result = {24'd0, byte_sel};
      ld_op[LD_H]:  result = {{16{half_sel[15]}}, half_sel};
      ld_op[LD_HU]: result = {16'd0, half_sel};
      default:      result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: load align/extend, rdata hold, forwarding.
// Optional misaligned-load exception enabled by MEM_ALE_CHK_EN.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  mem_stage_if.slave        es2ms,
  input  logic [DATA_W-1:0] data_sram_rdata,
  mem_stage_if.master       ms2ws,
  output logic [38:0]       ms_rf_zip,
  output logic              ms_ex,
  input  logic              wb_ex
);

  localparam logic [0:0] LIVE = 1'b0;
  localparam logic [0:0] HELD = 1'b1;

  logic              ms_valid_d;
  logic              ms_valid_q;
  es2ms_t            bundle_d;
  es2ms_t            bundle_q;
  logic [0:0]        state_d;
  logic [0:0]        state_q;
  logic [DATA_W-1:0] rdata_buf_d;
  logic [DATA_W-1:0] rdata_buf_q;

  logic              ms_allowin;
  logic [DATA_W-1:0] rdata_sel;
  logic [31:0]       ld_result;
  logic [31:0]       final_result;
  logic [EXC_W-1:0]  exc_out;
  logic              rf_we_out;
  ms2ws_t            out_bus;

  assign ms_allowin    = ~ms_valid_q | ms2ws.allowin;
  assign es2ms.allowin = ms_allowin;

  // Stage valid: flush wins, otherwise advance on allowin
  always_comb begin
    ms_valid_d = ms_valid_q;
    if (wb_ex) begin
      ms_valid_d = 1'b0;
    end else if (ms_allowin) begin
      ms_valid_d = es2ms.valid;
    end
  end

  // Bundle register: a flushed incoming bundle is never captured
  always_comb begin
    bundle_d = bundle_q;
    if (es2ms.valid & ms_allowin & ~wb_ex) begin
      bundle_d = es2ms_t'(es2ms.bus);
    end
  end

  // SRAM data lives one cycle; park it while write-back stalls
  always_comb begin
    state_d     = state_q;
    rdata_buf_d = rdata_buf_q;
    unique case (state_q)
      LIVE: begin
        if (ms_valid_q & bundle_q.res_from_mem &
            ~ms2ws.allowin & ~wb_ex) begin
          rdata_buf_d = data_sram_rdata;
          state_d     = HELD;
        end
      end
      HELD: begin
        if (ms2ws.allowin | wb_ex) begin
          state_d = LIVE;
        end
      end
      default: state_d = LIVE;
    endcase
  end

  // State update with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      ms_valid_q  <= 1'b0;
      bundle_q    <= '0;
      state_q     <= LIVE;
      rdata_buf_q <= '0;
    end else begin
      ms_valid_q  <= ms_valid_d;
      bundle_q    <= bundle_d;
      state_q     <= state_d;
      rdata_buf_q <= rdata_buf_d;
    end
  end

  assign rdata_sel = (state_q == HELD) ? rdata_buf_q
                                       : data_sram_rdata;

  load_ext u_load_ext (
    .rdata  (rdata_sel),
    .ld_op  (bundle_q.ld_op),
    .off    (bundle_q.alu_result[1:0]),
    .result (ld_result)
  );

  assign final_result = bundle_q.res_from_mem ? ld_result
                                              : bundle_q.alu_result;

`ifdef MEM_ALE_CHK_EN
  logic ale;

  assign ale = misaligned(bundle_q.ld_op,
                          bundle_q.alu_result[1:0]) &
               ~bundle_q.except_zip[EXC_FLAG_BIT];

  // Raise ALE unless an older exception already owns the slot
  always_comb begin
    exc_out   = bundle_q.except_zip;
    rf_we_out = bundle_q.rf_we;
    if (ale) begin
      exc_out[EXC_FLAG_BIT]        = 1'b1;
      exc_out[ECODE_LSB +: 6]      = ECODE_ALE;
      exc_out[BADV_LSB +: DATA_W]  = bundle_q.alu_result;
      rf_we_out                    = 1'b0;
    end
  end
`else
  // Exceptions from upstream pass straight through
  always_comb begin
    exc_out   = bundle_q.except_zip;
    rf_we_out = bundle_q.rf_we;
  end
`endif

  assign ms_ex = ms_valid_q & exc_out[EXC_FLAG_BIT];

  assign out_bus.rf_we        = rf_we_out;
  assign out_bus.rf_waddr     = bundle_q.rf_waddr;
  assign out_bus.final_result = final_result;
  assign out_bus.pc           = bundle_q.pc;
  assign out_bus.except_zip   = exc_out;

  assign ms2ws.valid = ms_valid_q;
  assign ms2ws.bus   = out_bus;

  assign ms_rf_zip = {
    bundle_q.res_from_mem & ms_valid_q,
    rf_we_out & ms_valid_q & ~ms_ex,
    bundle_q.rf_waddr,
    final_result
  };

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: load extension, stall hold, flush, exceptions.
// Build with +define+MEM_ALE_CHK_EN to exercise the misaligned-load check.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic              clk;
  logic              reset;
  logic [DATA_W-1:0] data_sram_rdata;
  logic [38:0]       ms_rf_zip;
  logic              ms_ex;
  logic              wb_ex;

  mem_stage_if #(.W(ES2MS_W)) es_if ();
  mem_stage_if #(.W(MS2WS_W)) ws_if ();

  ms2ws_t out;
  assign out = ms2ws_t'(ws_if.bus);

  int n_vec;
  int n_bad;

  mem_stage dut (
    .clk             (clk),
    .reset           (reset),
    .es2ms           (es_if),
    .data_sram_rdata (data_sram_rdata),
    .ms2ws           (ws_if),
    .ms_rf_zip       (ms_rf_zip),
    .ms_ex           (ms_ex),
    .wb_ex           (wb_ex)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(
    input string       tag,
    input logic [81:0] obs,
    input logic [81:0] exp
  );
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic es2ms_t mk(
    input logic [4:0]  op,
    input logic        rfm,
    input logic        we,
    input logic [4:0]  wa,
    input logic [31:0] alu,
    input logic [31:0] pc,
    input logic [81:0] exc
  );
    es2ms_t b;
    b.ld_op        = op;
    b.res_from_mem = rfm;
    b.rf_we        = we;
    b.rf_waddr     = wa;
    b.alu_result   = alu;
    b.pc           = pc;
    b.except_zip   = exc;
    return b;
  endfunction

  localparam logic [4:0] OP_B  = 5'b10000;
  localparam logic [4:0] OP_BU = 5'b01000;
  localparam logic [4:0] OP_H  = 5'b00100;
  localparam logic [4:0] OP_HU = 5'b00010;
  localparam logic [4:0] OP_W  = 5'b00001;
  localparam logic [4:0] OP_N  = 5'b00000;

  // Issue one bundle, then present its SRAM data in the MEM cycle
  task automatic issue(input es2ms_t b, input logic [31:0] rd);
    es_if.valid = 1'b1;
    es_if.bus   = b;
    step();
    es_if.valid     = 1'b0;
    data_sram_rdata = rd;
    #1;
  endtask

  initial begin
    logic [81:0] exc_flag;
    n_vec = 0;
    n_bad = 0;
    exc_flag = '0;
    exc_flag[81] = 1'b1;

    reset           = 1'b1;
    es_if.valid     = 1'b0;
    es_if.bus       = '0;
    ws_if.allowin   = 1'b1;
    wb_ex           = 1'b0;
    data_sram_rdata = '0;
    step();
    step();
    reset = 1'b0;
    #1;
    chk("rst_valid", ws_if.valid, 1'b0);
    chk("rst_ms_ex", ms_ex, 1'b0);
    chk("rst_rf_zip", ms_rf_zip, 39'd0);
    chk("rst_allowin", es_if.allowin, 1'b1);
    chk("rst_state", dut.state_q, 1'b0);

    issue(mk(OP_B, 1, 1, 5'd5, 32'h1003, 32'h100, '0),
          32'h80FF_1234);
    chk("ldb_res", out.final_result, 32'hFFFF_FF80);
    chk("ldb_valid", ws_if.valid, 1'b1);
    chk("ldb_zip", ms_rf_zip,
        {1'b1, 1'b1, 5'd5, 32'hFFFF_FF80});
    chk("ldb_pc", out.pc, 32'h100);

    issue(mk(OP_HU, 1, 1, 5'd6, 32'h2002, 32'h104, '0),
          32'h8001_0000);
    chk("ldhu_res", out.final_result, 32'h0000_8001);

    issue(mk(OP_H, 1, 1, 5'd6, 32'h2002, 32'h108, '0),
          32'h8001_0000);
    chk("ldh_res", out.final_result, 32'hFFFF_8001);

    issue(mk(OP_BU, 1, 1, 5'd8, 32'h2001, 32'h10C, '0),
          32'h1234_F600);
    chk("ldbu_res", out.final_result, 32'h0000_00F6);

    issue(mk(OP_B, 1, 1, 5'd8, 32'h2001, 32'h110, '0),
          32'h1234_F600);
    chk("ldb1_res", out.final_result, 32'hFFFF_FFF6);

    issue(mk(OP_W, 1, 1, 5'd9, 32'h3000, 32'h114, '0),
          32'h1234_5678);
    chk("ldw_res", out.final_result, 32'h1234_5678);

    issue(mk(OP_N, 0, 1, 5'd10, 32'hCAFE_0001, 32'h118, '0),
          32'h1111_1111);
    chk("alu_res", out.final_result, 32'hCAFE_0001);
    chk("alu_zip", ms_rf_zip,
        {1'b0, 1'b1, 5'd10, 32'hCAFE_0001});

    // Write-back stalls for three cycles while SRAM data changes
    issue(mk(OP_B, 1, 1, 5'd5, 32'h1003, 32'h11C, '0),
          32'h80FF_1234);
    ws_if.allowin = 1'b0;
    #1;
    chk("stall0_res", out.final_result, 32'hFFFF_FF80);
    chk("stall0_allowin", es_if.allowin, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      data_sram_rdata = 32'hDEAD_BEEF;
      #1;
      chk("stall_res", out.final_result, 32'hFFFF_FF80);
      chk("stall_allowin", es_if.allowin, 1'b0);
      chk("stall_valid", ws_if.valid, 1'b1);
    end
    ws_if.allowin = 1'b1;
    step();
    chk("drain_valid", ws_if.valid, 1'b0);
    chk("drain_state", dut.state_q, 1'b0);

    // Flush a stalled load
    issue(mk(OP_H, 1, 1, 5'd7, 32'h0010, 32'h120, '0),
          32'h0000_8001);
    ws_if.allowin = 1'b0;
    #1;
    chk("fl_res", out.final_result, 32'hFFFF_8001);
    step();
    chk("fl_held", dut.state_q, 1'b1);
    wb_ex = 1'b1;
    step();
    wb_ex = 1'b0;
    ws_if.allowin = 1'b1;
    #1;
    chk("fl_valid", ws_if.valid, 1'b0);
    chk("fl_state", dut.state_q, 1'b0);
    chk("fl_zip_we", ms_rf_zip[37], 1'b0);

    // Flush coincident with an incoming bundle
    es_if.valid = 1'b1;
    es_if.bus   = mk(OP_W, 1, 1, 5'd3, 32'h4000, 32'h124, '0);
    wb_ex       = 1'b1;
    step();
    es_if.valid = 1'b0;
    wb_ex       = 1'b0;
    #1;
    chk("co_valid", ws_if.valid, 1'b0);
    chk("co_allowin", es_if.allowin, 1'b1);

    // Upstream exception passes through, forwarding we gated
    issue(mk(OP_N, 0, 1, 5'd4, 32'h0000_0055, 32'h128, exc_flag),
          32'h0);
    chk("ex_ms_ex", ms_ex, 1'b1);
    chk("ex_zip_we", ms_rf_zip[37], 1'b0);
    chk("ex_bus_we", out.rf_we, 1'b1);
    chk("ex_res", out.final_result, 32'h0000_0055);

    // Misaligned word load
    issue(mk(OP_W, 1, 1, 5'd2, 32'h1002, 32'h12C, '0),
          32'hA5A5_0F0F);
`ifdef MEM_ALE_CHK_EN
    chk("ale_ms_ex", ms_ex, 1'b1);
    chk("ale_ecode", out.except_zip[ECODE_LSB +: 6], 6'h09);
    chk("ale_badv", out.except_zip[BADV_LSB +: 32], 32'h1002);
    chk("ale_we", out.rf_we, 1'b0);
`else
    chk("ale_ms_ex", ms_ex, 1'b0);
    chk("ale_we", out.rf_we, 1'b1);
    chk("ale_res", out.final_result, 32'hA5A5_0F0F);
    chk("ale_exc", out.except_zip, 82'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
